// File: rtl/enc_velocity.sv
// Gate-window velocity and edge-period measurement for the quadrature encoder counter stage.
// Optional `ENC_VEL_AVG_EN: velocity becomes the 4-gate running mean (one extra cycle latency).
module enc_velocity #(
    parameter int unsigned GATE_LEN = 100000,
    parameter int unsigned VEL_W    = 16,
    parameter int unsigned PER_W    = 24
) (
    input  logic                    i_clock,
    input  logic                    i_aclr_n,
    input  logic                    i_sclr,
    input  logic                    i_ready,
    input  logic signed [31:0]      i_bidir_counter,
    input  logic                    i_enc_changed,
    input  logic                    i_ovf_clr,
    output logic signed [VEL_W-1:0] o_velocity,
    output logic                    o_vel_valid,
    output logic [PER_W-1:0]        o_period,
    output logic                    o_period_valid,
    output logic                    o_stalled,
    output logic                    o_vel_ovf
);
    typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

    localparam logic [23:0]        GateLast = 24'(GATE_LEN - 1);
    localparam logic signed [31:0] VelMax   = (32'sd1 <<< (VEL_W - 1)) - 32'sd1;
    localparam logic signed [31:0] VelMin   = -(32'sd1 <<< (VEL_W - 1));
    localparam logic [PER_W-1:0]   PerMax   = '1;

    state_e                  r_state;
    logic [23:0]             r_gate_cnt;
    logic signed [31:0]      r_base;
    logic [PER_W-1:0]        r_per_cnt;
    logic                    r_edge_seen;
    logic signed [VEL_W-1:0] r_velocity;
    logic                    r_vel_valid;
    logic [PER_W-1:0]        r_period;
    logic                    r_period_valid;
    logic                    r_stalled;
    logic                    r_vel_ovf;

    logic signed [31:0]      w_delta;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic signed [VEL_W-1:0] w_vel_sat;
    logic                    w_terminal;
    logic [PER_W-1:0]        w_per_inc;

`ifdef ENC_VEL_AVG_EN
    logic signed [VEL_W-1:0] r_hist [4];
    logic [2:0]              r_gates;
    logic                    r_avg_pend;
    logic signed [VEL_W+1:0] w_sum;
    logic signed [VEL_W+1:0] w_avg;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 4; i++) begin
            w_sum = w_sum + {{2{r_hist[i][VEL_W-1]}}, r_hist[i]};
        end
        w_avg = w_sum >>> 2;
    end
`endif

    // Two's-complement subtraction makes 32-bit position wrap transparent.
    always_comb begin
        w_delta    = i_bidir_counter - r_base;
        w_sat_hi   = w_delta > VelMax;
        w_sat_lo   = w_delta < VelMin;
        w_vel_sat  = w_sat_hi ? VelMax[VEL_W-1:0] :
                     w_sat_lo ? VelMin[VEL_W-1:0] : w_delta[VEL_W-1:0];
        w_terminal = (r_gate_cnt == GateLast);
        w_per_inc  = (r_per_cnt == PerMax) ? PerMax : r_per_cnt + 1'b1;
    end

    always_ff @(posedge i_clock or negedge i_aclr_n) begin
        if (!i_aclr_n) begin
            r_state        <= StIdle;
            r_gate_cnt     <= '0;
            r_base         <= '0;
            r_per_cnt      <= '0;
            r_edge_seen    <= 1'b0;
            r_velocity     <= '0;
            r_vel_valid    <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_vel_ovf      <= 1'b0;
`ifdef ENC_VEL_AVG_EN
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_gates        <= '0;
            r_avg_pend     <= 1'b0;
`endif
        end else if (i_sclr) begin
            r_state        <= StIdle;
            r_gate_cnt     <= '0;
            r_base         <= '0;
            r_per_cnt      <= '0;
            r_edge_seen    <= 1'b0;
            r_velocity     <= '0;
            r_vel_valid    <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_vel_ovf      <= 1'b0;
`ifdef ENC_VEL_AVG_EN
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_gates        <= '0;
            r_avg_pend     <= 1'b0;
`endif
        end else begin
            r_vel_valid    <= 1'b0;
            r_period_valid <= 1'b0;
            if (i_ovf_clr) r_vel_ovf <= 1'b0;
`ifdef ENC_VEL_AVG_EN
            // A completed gate still reports its average even if ready drops meanwhile.
            r_avg_pend <= 1'b0;
            if (r_avg_pend) begin
                r_velocity  <= w_avg[VEL_W-1:0];
                r_vel_valid <= 1'b1;
            end
`endif
            if (!i_ready) begin
                r_state    <= StIdle;
                r_gate_cnt <= '0;
                r_per_cnt  <= '0;
                r_stalled  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: r_state <= StArm;
                    StArm: begin
                        r_base      <= i_bidir_counter;
                        r_gate_cnt  <= '0;
                        r_per_cnt   <= '0;
                        r_edge_seen <= 1'b0;
`ifdef ENC_VEL_AVG_EN
                        r_gates     <= '0;
`endif
                        r_state     <= StRun;
                    end
                    StRun: begin
                        if (w_terminal) begin
                            r_base     <= i_bidir_counter;
                            r_gate_cnt <= '0;
                            if (w_sat_hi || w_sat_lo) r_vel_ovf <= 1'b1;
`ifdef ENC_VEL_AVG_EN
                            r_hist[0]  <= w_vel_sat;
                            r_hist[1]  <= r_hist[0];
                            r_hist[2]  <= r_hist[1];
                            r_hist[3]  <= r_hist[2];
                            r_gates    <= (r_gates == 3'd4) ? 3'd4 : r_gates + 1'b1;
                            r_avg_pend <= (r_gates >= 3'd3);
`else
                            r_velocity  <= w_vel_sat;
                            r_vel_valid <= 1'b1;
`endif
                        end else begin
                            r_gate_cnt <= r_gate_cnt + 1'b1;
                        end
                        // First edge after ARM only starts the interval.
                        if (i_enc_changed) begin
                            if (r_edge_seen) begin
                                r_period       <= w_per_inc;
                                r_period_valid <= 1'b1;
                            end
                            r_per_cnt   <= '0;
                            r_edge_seen <= 1'b1;
                            r_stalled   <= 1'b0;
                        end else begin
                            r_per_cnt <= w_per_inc;
                            if (w_per_inc == PerMax) r_stalled <= 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_velocity     = r_velocity;
    assign o_vel_valid    = r_vel_valid;
    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;
    assign o_stalled      = r_stalled;
    assign o_vel_ovf      = r_vel_ovf;

endmodule
